// File: rtl/multiword_add_ctrl.sv
// Sequences a WIDTH-bit add/subtract through an external SLICE-bit CLA slice,
// one digit per cycle (LSB first), and reports sum, carry-out and overflow.
module multiword_add_ctrl #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  input  logic             sub,
  output logic [SLICE-1:0] slice_a,
  output logic [SLICE-1:0] slice_b,
  output logic             slice_ci,
  input  logic [SLICE-1:0] slice_s,
  input  logic             slice_co,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, res_sr, res_nxt, b_eff;
  logic [CW-1:0]    cnt;
  logic             carry, a_msb, b_msb, last;

  assign b_eff = sub ? ~b_in : b_in;
  assign last  = (cnt == CW'(N - 1));

  // Result fills from the top so the LSB digit ends up at bit 0 after N shifts.
  generate
    if (N == 1) begin : g_one
      assign res_nxt = slice_s;
    end else begin : g_multi
      assign res_nxt = {slice_s, res_sr[WIDTH-1:SLICE]};
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign slice_a  = (state == RUN) ? a_reg[SLICE-1:0] : '0;
  assign slice_b  = (state == RUN) ? b_reg[SLICE-1:0] : '0;
  assign slice_ci = (state == RUN) ? carry : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_reg <= a_in;
          b_reg <= b_eff;
          carry <= sub | cin;  // subtract is A + ~B + 1, cin ignored
          cnt   <= '0;
          a_msb <= a_in[WIDTH-1];
          b_msb <= b_eff[WIDTH-1];
        end
        RUN: begin
          res_sr <= res_nxt;
          carry  <= slice_co;
          a_reg  <= a_reg >> SLICE;
          b_reg  <= b_reg >> SLICE;
          cnt    <= cnt + 1'b1;
          if (last) begin
            sum  <= res_nxt;
            cout <= slice_co;
            ovf  <= (a_msb == b_msb) && (res_nxt[WIDTH-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Scoreboarded bench for multiword_add_ctrl with a behavioural 4-bit slice;
// expected results come from plain signed/unsigned arithmetic.
module tb_multiword_add_ctrl;
  localparam int WIDTH = 32;
  localparam int SLICE = 4;
  localparam int N     = WIDTH / SLICE;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, cin, sub;
  logic [WIDTH-1:0] a_in, b_in;
  logic [SLICE-1:0] slice_a, slice_b, slice_s;
  logic             slice_ci, slice_co;
  logic             busy, done, cout, ovf;
  logic [WIDTH-1:0] sum;
  logic [SLICE:0]   slice_t;

  int n_chk  = 0;
  int n_fail = 0;
  exp_t sb[$];
  logic [WIDTH-1:0] prev_sum;

  always #5 clk = ~clk;

  assign slice_t = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE{1'b0}}, slice_ci};
  assign slice_s  = slice_t[SLICE-1:0];
  assign slice_co = slice_t[SLICE];

  multiword_add_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .cin(cin), .sub(sub), .slice_a(slice_a), .slice_b(slice_b),
    .slice_ci(slice_ci), .slice_s(slice_s), .slice_co(slice_co),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  function automatic exp_t model(input logic [31:0] a, b, input logic c, s);
    exp_t   e;
    longint sa, sbv, r, u;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (s) begin
      r   = sa - sbv;
      e.s = a - b;
      e.c = (a >= b);
    end else begin
      r   = sa + sbv + longint'(c);
      u   = longint'(a) + longint'(b) + longint'(c);
      e.s = u[31:0];
      e.c = u[32];
    end
    e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sum", {32'd0, sum}, {32'd0, e.s});
        chk("cout", {63'd0, cout}, {63'd0, e.c});
        chk("ovf", {63'd0, ovf}, {63'd0, e.o});
      end
    end
  end

  // One operation from IDLE; optional spurious start in RUN cycle 3.
  task automatic op(input logic [31:0] a, b, input logic c, s, input bit inj);
    int   cyc;
    bit   got;
    exp_t e;
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b; cin = c; sub = s;
    e = model(a, b, c, s);
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    got = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (inj && cyc == 3) begin
        start = 1'b1; a_in = $urandom; b_in = $urandom; cin = 1'b1; sub = 1'b0;
      end
      if (inj && cyc == 4) start = 1'b0;
      if (cyc == 4) chk("sum_hold_in_run", {32'd0, sum}, {32'd0, prev_sum});
      if (done) got = 1;
    end
    chk("done_latency", 64'(cyc), 64'(N + 1));
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("busy_fall", {63'd0, busy}, 64'd0);
    prev_sum = e.s;
  endtask

  initial begin
    int dc[3];
    int ndone;
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0; sub = 1'b0;
    prev_sum = '0;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_sum", {32'd0, sum}, 64'd0);
    chk("rst_flags", {62'd0, cout, ovf}, 64'd0);
    chk("rst_slice", {55'd0, slice_a, slice_b, slice_ci}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op(32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
    op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
    op(32'h00000005, 32'h00000007, 1'b1, 1'b1, 0);
    op(32'h0000ABCD, 32'h00001234, 1'b0, 1'b1, 1);

    // Abort mid-RUN: no push, so any done pulse is flagged by the monitor.
    @(negedge clk);
    start = 1'b1; a_in = 32'hDEADBEEF; b_in = 32'h01234567; cin = 1'b0; sub = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    chk("slice_active_in_run", {63'd0, busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_sum", {32'd0, sum}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_slice", {55'd0, slice_a, slice_b, slice_ci}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_sum = '0;
    op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 0);

    // start held high for 30 cycles
    @(negedge clk);
    start = 1'b1; a_in = 32'h80000000; b_in = 32'h80000000; cin = 1'b0; sub = 1'b0;
    repeat (3) sb.push_back(model(32'h80000000, 32'h80000000, 1'b0, 1'b0));
    ndone = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (done) begin
        if (ndone < 3) dc[ndone] = cyc;
        ndone++;
      end
    end
    start = 1'b0;
    chk("held_done_count", 64'(ndone), 64'd3);
    chk("held_done_0", 64'(dc[0]), 64'(N + 1));
    chk("held_done_1", 64'(dc[1]), 64'(2 * N + 3));
    chk("held_done_2", 64'(dc[2]), 64'(3 * N + 5));
    repeat (2) @(negedge clk);
    chk("held_idle", {63'd0, busy}, 64'd0);
    prev_sum = 32'h00000000;

    op(32'h80000000, 32'h00000001, 1'b0, 1'b1, 0);
    op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 0);
    op(32'h00000000, 32'h00000000, 1'b0, 1'b1, 0);
    for (int i = 0; i < 40; i++)
      op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0));

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
